// File: rtl/eeg_frame_assembler.sv
// eeg_frame_assembler
//   Collects a serial stream of Q8.8 EEG samples into one FEATURE_COUNT-sample
//   frame. The frame is handed to the seizure detector with a one-cycle
//   frame_valid pulse, then held frozen until the detector answers (det_done)
//   or DONE_TIMEOUT HOLD cycles elapse.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready     sample handshake; s_first marks sample 0 of a frame
//   s_data              input sample, DATA_WIDTH bits
//   det_ready           detector idle; a complete frame waits for it
//   det_done            detector result pulse, honoured only in HOLD
//   frame_valid         one-cycle frame handoff pulse (registered)
//   frame_data          assembled frame, unpacked array of FEATURE_COUNT samples
//   frame_count         frames issued, wraps
//   drop_count          unaligned samples discarded, saturates
//   resync_err          sticky: s_first seen while a frame was partly filled
//   timeout_err         sticky: HOLD ended by timeout rather than det_done
//   state_dbg           current FSM state (0 FILL, 1 WAIT_RDY, 2 ISSUE, 3 HOLD)
//
// Handshake: a sample transfers on a rising edge where s_valid && s_ready.
// s_ready is a pure decode of the registered state, so it never depends on
// s_valid in the same cycle, and the source must keep s_valid/s_data stable
// while s_ready is low if it wants the sample taken.
module eeg_frame_assembler #(
  parameter int DATA_WIDTH    = 16,
  parameter int FEATURE_COUNT = 178,
  parameter int DONE_TIMEOUT  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  input  logic                  s_first,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  det_ready,
  input  logic                  det_done,
  output logic                  frame_valid,
  output logic [DATA_WIDTH-1:0] frame_data [FEATURE_COUNT],
  output logic [15:0]           frame_count,
  output logic [15:0]           drop_count,
  output logic                  resync_err,
  output logic                  timeout_err,
  output logic [1:0]            state_dbg
);

  localparam int IW = $clog2(FEATURE_COUNT + 1);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FEATURE_COUNT - 1);
  localparam logic [TW-1:0] LAST_HOLD = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    WAIT_RDY = 2'd1,
    ISSUE    = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [TW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic [15:0]           drop_count_q, drop_count_d;
  logic                  resync_q, resync_d;
  logic                  timeout_q, timeout_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  wr_en;
  logic [IW-1:0]         wr_idx;
  logic [DATA_WIDTH-1:0] frame_data_q [FEATURE_COUNT];
  logic                  accept;

  assign accept = s_valid && (state_q == FILL);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    hold_cnt_d    = hold_cnt_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    resync_d      = resync_q;
    timeout_d     = timeout_q;
    frame_valid_d = 1'b0;
    wr_en         = 1'b0;
    wr_idx        = idx_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (s_first) begin
            // A marker always restarts the frame, even on the final index;
            // the abandoned partial frame is flagged but not counted as drops.
            wr_en  = 1'b1;
            wr_idx = '0;
            if (idx_q != '0) resync_d = 1'b1;
            if (FEATURE_COUNT == 1) begin
              idx_d   = '0;
              state_d = WAIT_RDY;
            end else begin
              idx_d = IW'(1);
            end
          end else if (idx_q == '0) begin
            // No frame in progress: sample cannot be placed, discard it.
            if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
          end else begin
            wr_en = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = WAIT_RDY;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
      end
      WAIT_RDY: begin
        if (det_ready) begin
          state_d       = ISSUE;
          frame_valid_d = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      ISSUE: begin
        state_d    = HOLD;
        hold_cnt_d = '0;
      end
      HOLD: begin
        // det_done has priority over a timeout expiring in the same cycle.
        if (det_done) begin
          state_d = FILL;
        end else if (hold_cnt_q == LAST_HOLD) begin
          state_d   = FILL;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + TW'(1);
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      idx_q         <= '0;
      hold_cnt_q    <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      resync_q      <= 1'b0;
      timeout_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      for (int i = 0; i < FEATURE_COUNT; i++) frame_data_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      hold_cnt_q    <= hold_cnt_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      resync_q      <= resync_d;
      timeout_q     <= timeout_d;
      frame_valid_q <= frame_valid_d;
      // Writes happen only in FILL, so the frame is frozen from WAIT_RDY on.
      if (wr_en) frame_data_q[wr_idx] <= s_data;
    end
  end

  assign s_ready     = (state_q == FILL);
  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign resync_err  = resync_q;
  assign timeout_err = timeout_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_eeg_frame_assembler.sv
module tb_eeg_frame_assembler;

  localparam int DW = 16;
  localparam int FC = 178;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_first = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          det_ready = 1'b1;
  logic          det_done = 1'b0;
  logic          frame_valid;
  logic [DW-1:0] frame_data [FC];
  logic [15:0]   frame_count;
  logic [15:0]   drop_count;
  logic          resync_err;
  logic          timeout_err;
  logic [1:0]    state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int fv_pulses = 0;
  int p0;

  eeg_frame_assembler #(
    .DATA_WIDTH(DW), .FEATURE_COUNT(FC), .DONE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_first(s_first),
    .s_data(s_data), .s_ready(s_ready), .det_ready(det_ready),
    .det_done(det_done), .frame_valid(frame_valid), .frame_data(frame_data),
    .frame_count(frame_count), .drop_count(drop_count),
    .resync_err(resync_err), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid === 1'b1) fv_pulses++;

  initial begin
    #1000000;
    $display("FAIL watchdog expired n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic first, input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_first = first;
    s_data  = d;
    step();
    s_valid = 1'b0;
    s_first = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < FC; i++) send(i == 0, DW'(base + i));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_first = 1'b0;
    det_done = 1'b0;
    det_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic release_hold();
    det_done = 1'b1;
    step();
    det_done = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rst_s_ready got %0b exp 1", s_ready); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL rst_frame_valid got %0b exp 0", frame_valid); end
    n_cmp++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL rst_frame_count got %0d exp 0", frame_count); end
    n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL rst_drop_count got %0d exp 0", drop_count); end
    n_cmp++; if (resync_err !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_flags got %0b%0b exp 00", resync_err, timeout_err); end
    n_cmp++; if (frame_data[0] !== 16'd0 || frame_data[FC-1] !== 16'd0) begin n_err++; $display("FAIL rst_frame_data got %0d/%0d exp 0/0", frame_data[0], frame_data[FC-1]); end
    n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d exp 0", state_dbg); end
  endtask

  task automatic test_single_frame();
    det_ready = 1'b1;
    send_frame(1);
    n_cmp++; if (frame_valid !== 1'b0 || s_ready !== 1'b0) begin n_err++; $display("FAIL sf_wait fv=%0b rdy=%0b exp 0/0", frame_valid, s_ready); end
    step();
    n_cmp++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL sf_fv_latency got %0b exp 1", frame_valid); end
    n_cmp++; if (frame_data[0] !== 16'd1) begin n_err++; $display("FAIL sf_data0 got %0d exp 1", frame_data[0]); end
    n_cmp++; if (frame_data[FC-1] !== 16'd178) begin n_err++; $display("FAIL sf_data177 got %0d exp 178", frame_data[FC-1]); end
    n_cmp++; if (frame_count !== 16'd1) begin n_err++; $display("FAIL sf_frame_count got %0d exp 1", frame_count); end
    step();
    n_cmp++; if (frame_valid !== 1'b0 || state_dbg !== 2'd3) begin n_err++; $display("FAIL sf_hold fv=%0b state=%0d exp 0/3", frame_valid, state_dbg); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL sf_hold_s_ready cyc %0d got %0b exp 0", i, s_ready); end
    end
    release_hold();
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL sf_release got %0b exp 1", s_ready); end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 5; i++) send(1'b0, DW'(16'h0AA0 + i));
    n_cmp++; if (drop_count !== 16'd5) begin n_err++; $display("FAIL drop_count got %0d exp 5", drop_count); end
    send_frame(1000);
    step();
    n_cmp++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL drop_fv got %0b exp 1", frame_valid); end
    n_cmp++; if (frame_data[0] !== 16'd1000 || frame_data[FC-1] !== 16'd1177) begin n_err++; $display("FAIL drop_data got %0d/%0d exp 1000/1177", frame_data[0], frame_data[FC-1]); end
    n_cmp++; if (frame_count !== 16'd2 || drop_count !== 16'd5) begin n_err++; $display("FAIL drop_counts got %0d/%0d exp 2/5", frame_count, drop_count); end
    step();
    release_hold();
  endtask

  task automatic test_resync();
    p0 = fv_pulses;
    send(1'b1, 16'd2000);
    for (int i = 1; i < 59; i++) send(1'b0, DW'(2000 + i));
    n_cmp++; if (resync_err !== 1'b0) begin n_err++; $display("FAIL rs_pre got %0b exp 0", resync_err); end
    send_frame(3000);
    n_cmp++; if (resync_err !== 1'b1) begin n_err++; $display("FAIL rs_flag got %0b exp 1", resync_err); end
    n_cmp++; if (drop_count !== 16'd5) begin n_err++; $display("FAIL rs_drop got %0d exp 5", drop_count); end
    step();
    step();
    n_cmp++; if (fv_pulses - p0 !== 1) begin n_err++; $display("FAIL rs_pulses got %0d exp 1", fv_pulses - p0); end
    n_cmp++; if (frame_data[0] !== 16'd3000 || frame_data[59] !== 16'd3059 || frame_data[FC-1] !== 16'd3177) begin n_err++; $display("FAIL rs_data got %0d/%0d/%0d exp 3000/3059/3177", frame_data[0], frame_data[59], frame_data[FC-1]); end
    n_cmp++; if (frame_count !== 16'd3) begin n_err++; $display("FAIL rs_frame_count got %0d exp 3", frame_count); end
    release_hold();
  endtask

  task automatic test_det_ready_stall();
    det_ready = 1'b0;
    p0 = fv_pulses;
    send_frame(4000);
    repeat (20) step();
    n_cmp++; if (fv_pulses !== p0) begin n_err++; $display("FAIL st_no_pulse got %0d exp 0", fv_pulses - p0); end
    n_cmp++; if (s_ready !== 1'b0 || state_dbg !== 2'd1) begin n_err++; $display("FAIL st_wait rdy=%0b state=%0d exp 0/1", s_ready, state_dbg); end
    det_ready = 1'b1;
    step();
    n_cmp++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL st_fv got %0b exp 1", frame_valid); end
    n_cmp++; if (frame_data[0] !== 16'd4000 || frame_data[100] !== 16'd4100) begin n_err++; $display("FAIL st_data got %0d/%0d exp 4000/4100", frame_data[0], frame_data[100]); end
    n_cmp++; if (frame_count !== 16'd4) begin n_err++; $display("FAIL st_frame_count got %0d exp 4", frame_count); end
    step();
    n_cmp++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL st_fv_once got %0b exp 0", frame_valid); end
    release_hold();
  endtask

  task automatic test_timeout();
    send_frame(5000);
    step();
    step();
    repeat (TO - 1) step();
    n_cmp++; if (s_ready !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL to_early rdy=%0b to=%0b exp 0/0", s_ready, timeout_err); end
    step();
    n_cmp++; if (s_ready !== 1'b1 || timeout_err !== 1'b1) begin n_err++; $display("FAIL to_expire rdy=%0b to=%0b exp 1/1", s_ready, timeout_err); end
    do_reset();
    send_frame(6000);
    step();
    step();
    repeat (TO - 1) step();
    det_done = 1'b1;
    step();
    det_done = 1'b0;
    n_cmp++; if (s_ready !== 1'b1 || timeout_err !== 1'b0) begin n_err++; $display("FAIL to_done_wins rdy=%0b to=%0b exp 1/0", s_ready, timeout_err); end
    n_cmp++; if (frame_count !== 16'd1) begin n_err++; $display("FAIL to_frame_count got %0d exp 1", frame_count); end
  endtask

  task automatic test_restart_on_last();
    for (int i = 0; i < FC - 1; i++) send(i == 0, DW'(7000 + i));
    send(1'b1, 16'd7777);
    n_cmp++; if (s_ready !== 1'b1 || resync_err !== 1'b1) begin n_err++; $display("FAIL rl_restart rdy=%0b rs=%0b exp 1/1", s_ready, resync_err); end
    for (int i = 1; i < FC; i++) send(1'b0, DW'(7777 + i));
    step();
    n_cmp++; if (frame_valid !== 1'b1 || frame_count !== 16'd2) begin n_err++; $display("FAIL rl_issue fv=%0b cnt=%0d exp 1/2", frame_valid, frame_count); end
    n_cmp++; if (frame_data[0] !== 16'd7777 || frame_data[FC-1] !== 16'd7954) begin n_err++; $display("FAIL rl_data got %0d/%0d exp 7777/7954", frame_data[0], frame_data[FC-1]); end
    step();
  endtask

  task automatic test_reset_in_hold();
    n_cmp++; if (state_dbg !== 2'd3) begin n_err++; $display("FAIL rh_in_hold got %0d exp 3", state_dbg); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (s_ready !== 1'b1 || frame_valid !== 1'b0) begin n_err++; $display("FAIL rh_async rdy=%0b fv=%0b exp 1/0", s_ready, frame_valid); end
    n_cmp++; if (frame_count !== 16'd0 || resync_err !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL rh_state cnt=%0d rs=%0b to=%0b exp 0/0/0", frame_count, resync_err, timeout_err); end
    n_cmp++; if (frame_data[0] !== 16'd0 || frame_data[FC-1] !== 16'd0) begin n_err++; $display("FAIL rh_data got %0d/%0d exp 0/0", frame_data[0], frame_data[FC-1]); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++; if (s_ready !== 1'b1 || state_dbg !== 2'd0) begin n_err++; $display("FAIL rh_release rdy=%0b state=%0d exp 1/0", s_ready, state_dbg); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_drop();
    test_resync();
    test_det_ready_stall();
    test_timeout();
    test_restart_on_last();
    test_reset_in_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eeg_frame_assembler.md
# eeg_frame_assembler

Upstream stage of the seizure detection system. Accepts a serial stream of Q8.8 EEG samples, assembles them into one FEATURE_COUNT-sample frame, and presents the frame in parallel to the detector with a one-cycle `frame_valid` pulse. It holds the frame stable until the detector reports a result, or until a timeout expires. Stream alignment uses a first-sample marker. Misaligned or aborted frames are counted, never forwarded.

## Interface
- `DATA_WIDTH`, 16, sample width (Q8.8).
- `FEATURE_COUNT`, 178, samples per frame.
- `DONE_TIMEOUT`, 4096, maximum HOLD cycles before the frame is force-released.
- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_valid`  in  1  input sample valid.
- `s_first`  in  1  qualifies `s_data` as sample 0 of a frame.
- `s_data`  in  DATA_WIDTH  input sample.
- `s_ready`  out  1  assembler accepts a sample this cycle.
- `det_ready`  in  1  detector idle; connects to detector `system_ready`.
- `det_done`  in  1  detector result pulse; connects to detector `result_valid`.
- `frame_valid`  out  1  one-cycle frame handoff; connects to detector `data_valid`.
- `frame_data`  out  DATA_WIDTH x FEATURE_COUNT (unpacked)  assembled frame.
- `frame_count`  out  16  frames issued, wraps at 2^16.
- `drop_count`  out  16  samples discarded, saturates at 0xFFFF.
- `resync_err`  out  1  sticky: `s_first` arrived mid-frame.
- `timeout_err`  out  1  sticky: HOLD hit DONE_TIMEOUT.

## Operation
- States:
  - FILL: collecting samples.
  - WAIT_RDY: frame complete, waiting for the detector.
  - ISSUE: one cycle, `frame_valid` high.
  - HOLD: frame frozen until `det_done` or timeout.
- `s_ready` = (state == FILL), decoded from registered state only.
- An accept occurs when `s_valid && s_ready`. Index counter `idx` has width clog2(FEATURE_COUNT+1).
- Accept with `s_first`: write `frame_data[0]` and set `idx`=1. If `idx`≠0 beforehand, set `resync_err`; the partial frame is abandoned and is not counted in `drop_count`.
- Accept without `s_first` and `idx`==0: the sample is discarded and `drop_count` increments.
- Accept without `s_first` and `idx`>0: write `frame_data[idx]` and increment `idx`.
- The accept that writes index FEATURE_COUNT-1 moves the FSM FILL→WAIT_RDY and clears `idx` to 0.
- WAIT_RDY→ISSUE when `det_ready`==1. WAIT_RDY stays put otherwise, with no limit.
- ISSUE→HOLD unconditionally. `frame_count` increments on entry to ISSUE.
- HOLD→FILL when `det_done`==1, or when the HOLD cycle counter reaches DONE_TIMEOUT. The timeout path sets `timeout_err`. The counter clears on HOLD entry.
- `frame_data` is written only in FILL, so it is stable from WAIT_RDY through HOLD.
- `det_done` is ignored outside HOLD.
- Sticky flags clear only on reset.

## Timing
- Reset values:
  - state = FILL, so `s_ready`=1 in the first cycle after reset release.
  - `frame_valid`=0, `frame_data` all 0.
  - `frame_count`=0, `drop_count`=0, `idx`=0.
  - `resync_err`=0, `timeout_err`=0.
- Reset asserted mid-operation: everything returns to reset values immediately. A partial or held frame is lost and is not counted.
- `frame_valid` is registered: high exactly one cycle, one cycle after the WAIT_RDY cycle that sees `det_ready`=1.
- Minimum latency, last sample accepted to `frame_valid`: 2 cycles (WAIT_RDY, then ISSUE), given `det_ready`=1.
- `s_ready` drops the cycle after the last sample is accepted. It rises the cycle after the HOLD exit condition.
- Throughput: one sample per cycle in FILL.
- `det_done` in the same cycle as the timeout: treated as done, `timeout_err` not set.
- `s_first` on the final-index accept: restart wins. `idx`=1, `resync_err` set, the FSM stays in FILL.
- FEATURE_COUNT=1: every `s_first` accept completes a frame.

## Test plan
- Reset, then 178 consecutive samples with values 1..178, `s_first` on sample 1, `det_ready`=1. Expect:
  - `frame_valid` high 2 cycles after the last accept;
  - `frame_data[0]`=1 and `frame_data[177]`=178;
  - `frame_count`=1;
  - `s_ready`=0 through HOLD.
- 5 samples without `s_first`, then a valid frame. Expect `drop_count`=5 and the frame issued correctly.
- `s_first` at sample 60 of a frame, followed by 178 samples. Expect `resync_err`=1, exactly one `frame_valid`, and `frame_data[0]` = the second `s_first` value.
- Full frame with `det_ready`=0 for 20 cycles. Expect no `frame_valid` while `det_ready`=0, then one pulse 1 cycle after `det_ready` rises, and `frame_data` unchanged.
- HOLD with no `det_done` and DONE_TIMEOUT=16. Expect return to FILL after 16 cycles with `timeout_err`=1. Repeat with `det_done` on cycle 16: `timeout_err` stays 0.
- Assert `rst_n` low in HOLD. Expect all outputs at reset values asynchronously and `s_ready`=1 after release.
